// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and frame sizing.
package uart_pkg;

  // Shortest frame is 7 data bits plus the stop bit. The shift register
  // holds the longest frame: 8 data bits, parity and stop.
  localparam int unsigned MIN_BITS = 8;
  localparam int unsigned SR_W     = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_remap.sv
// Right-justifies a received frame.
// The receiver shifts each sampled bit in at the top of the register, so a
// frame of N bits ends up in d_in[SR_W-1 -: N]. This block moves the frame
// down so that the first data bit lands at d_out[0].
module uart_rx_ctrl_remap
  import uart_pkg::*;
(
  input  logic [SR_W-1:0] d_in,
  input  logic            eight,
  input  logic            pen,
  output logic [SR_W-1:0] d_out
);

  // The shift amount is SR_W minus the frame length. It can be 0, 1 or 2.
  always_comb begin
    d_out = d_in;
    unique case ({eight, pen})
      2'b11:        d_out = d_in;
      2'b10, 2'b01: d_out = d_in >> 1;
      default:      d_out = d_in >> 2;
    endcase
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-engine controller.
// It synchronizes rx and validates the start bit at mid-bit. It then samples
// each following bit at mid-bit and shifts it into a 10-bit register. The
// finished frame is latched as data plus parity, framing and overrun status.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  input  logic [BAUD_W-1:0] baud_k,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic              clr_rdy,
  output logic [7:0]        rx_data,
  output logic              rxrdy,
  output logic              perr,
  output logic              ferr,
  output logic              ovf
);

  rx_state_t         state, state_nxt;
  logic              rx_meta, rx_s;
  logic [BAUD_W-1:0] cnt;
  logic [3:0]        bit_cnt;
  logic [SR_W-1:0]   sr;
  logic              cfg_eight, cfg_pen;
  logic [SR_W-1:0]   d_out;

  logic [BAUD_W-1:0] half_k, last_k;
  logic              hit_half, hit_bit, last_bit;
  logic [3:0]        frame_bits;
  logic [7:0]        data;
  logic              par_bit, stop_bit, exp_par;

  // Two-flop synchronizer. It resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Terminal counts and frame length.
  always_comb begin
    half_k     = baud_k >> 1;
    last_k     = baud_k - BAUD_W'(1);
    hit_half   = (cnt == half_k);
    hit_bit    = (cnt == last_k);
    frame_bits = 4'(MIN_BITS) + {3'b000, cfg_eight} + {3'b000, cfg_pen};
    last_bit   = (bit_cnt == frame_bits - 4'd1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic. A start bit that reads high again at mid-bit is a
  // false start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (hit_half) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (hit_bit && last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit-time counter, bit counter, shift register and per-frame config.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      cfg_eight <= 1'b0;
      cfg_pen   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!rx_s) begin
            cfg_eight <= eight;
            cfg_pen   <= pen;
          end
        end
        START: cnt <= hit_half ? '0 : cnt + BAUD_W'(1);
        DATA: begin
          if (hit_bit) begin
            cnt     <= '0;
            sr      <= {rx_s, sr[SR_W-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
        default: begin
          cnt     <= '0;
          bit_cnt <= '0;
          sr      <= '0;
        end
      endcase
    end
  end

  uart_rx_ctrl_remap u_remap (
    .d_in  (sr),
    .eight (cfg_eight),
    .pen   (cfg_pen),
    .d_out (d_out)
  );

  // Pull data, parity and stop fields out of the right-justified frame.
  always_comb begin
    data     = cfg_eight ? d_out[7:0] : {1'b0, d_out[6:0]};
    par_bit  = cfg_eight ? d_out[8] : d_out[7];
    stop_bit = d_out[frame_bits - 4'd1];
    exp_par  = (^data) ^ ohel;
  end

  // Status registers. A completing frame always sets rxrdy. When clr_rdy
  // arrives in the same cycle, the read is of the older data, so no overrun
  // is flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data <= '0;
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (state == DONE) begin
      rx_data <= data;
      perr    <= cfg_pen & (par_bit != exp_par);
      ferr    <= ~stop_bit;
      rxrdy   <= 1'b1;
      ovf     <= rxrdy & ~clr_rdy;
    end else if (clr_rdy) begin
      rxrdy <= 1'b0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl. Frames are built from a serial-line description
// and checked against an abstract model of the receive status.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx;
  logic [18:0] baud_k;
  logic        eight, pen, ohel, clr_rdy;
  logic [7:0]  rx_data;
  logic        rxrdy, perr, ferr, ovf;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned baud = 16;

  // Reference model of the processor-visible status.
  logic [7:0] m_data;
  logic       m_rdy, m_perr, m_ferr, m_ovf;

  uart_rx_ctrl #(.BAUD_W(19)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .baud_k  (baud_k),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rxrdy   (rxrdy),
    .perr    (perr),
    .ferr    (ferr),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, ".rx_data"}, 32'(rx_data), 32'(m_data));
    check({where, ".rxrdy"},   32'(rxrdy),   32'(m_rdy));
    check({where, ".perr"},    32'(perr),    32'(m_perr));
    check({where, ".ferr"},    32'(ferr),    32'(m_ferr));
    check({where, ".ovf"},     32'(ovf),     32'(m_ovf));
  endtask

  task automatic model_reset();
    m_data = '0; m_rdy = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
  endtask

  // Hold one line level for one bit time. The caller is at a negedge.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (baud) @(negedge clk);
  endtask

  // Send one frame. With scramble set, eight/pen toggle after the start bit.
  // The model must still follow the settings in force at the start bit.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic e,
                            input logic p, input logic o, input logic pb,
                            input logic sb, input logic scramble);
    logic       pre_rdy;
    logic [7:0] eff;
    pre_rdy = m_rdy;
    eight = e; pen = p; ohel = o; baud_k = 19'(baud);
    send_bit(1'b0);
    if (scramble) begin
      eight = ~e;
      pen   = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < (e ? 8 : 7); i++) send_bit(d[i]);
    if (p) send_bit(pb);
    check({tag, ".rdy_before_stop"}, 32'(rxrdy), 32'(pre_rdy));
    send_bit(sb);
    rx = 1'b1; eight = e; pen = p;
    repeat (baud) @(negedge clk);
    eff    = e ? d : {1'b0, d[6:0]};
    m_ovf  = m_rdy;
    m_rdy  = 1'b1;
    m_data = eff;
    m_perr = p && (pb != ((^eff) ^ o));
    m_ferr = ~sb;
    check_outputs(tag);
  endtask

  task automatic pulse_clr(input string tag);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    m_rdy = 0; m_ovf = 0;
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] d;
    logic       e, p, o, pb, sb, sc;

    reset_n = 1'b0; rx = 1'b1; baud_k = 19'd16;
    eight = 1'b1; pen = 1'b0; ohel = 1'b0; clr_rdy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5
    send_frame("8n1_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_clr("clr1");
    // 7E1 0x41 with correct and then wrong parity
    send_frame("7e1_ok", 8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_clr("clr2");
    send_frame("7e1_bad", 8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_clr("clr3");
    // 8O1 0x00, good odd parity, broken stop bit
    send_frame("8o1_ferr", 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_clr("clr4");

    // Start glitch shorter than half a bit
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * baud) @(negedge clk);
    check_outputs("glitch");

    // Overrun
    send_frame("ovr_a", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame("ovr_b", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_clr("ovr_clr");

    // Reset in the middle of the data bits
    eight = 1'b1; pen = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * baud) @(negedge clk);
    send_frame("post_reset", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_clr("clr5");

    // Random frames and configurations
    for (int n = 0; n < 24; n++) begin
      baud = $urandom_range(4, 20);
      d  = 8'($urandom);
      e  = 1'($urandom_range(0, 1));
      p  = 1'($urandom_range(0, 1));
      o  = 1'($urandom_range(0, 1));
      sc = 1'($urandom_range(0, 1));
      pb = (^(e ? d : {1'b0, d[6:0]})) ^ o;
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      sb = ($urandom_range(0, 7) != 0);
      send_frame($sformatf("rnd%0d", n), d, e, p, o, pb, sb, sc);
      if ($urandom_range(0, 2) != 0) pulse_clr($sformatf("rnd_clr%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-engine controller for the UART peripheral.
- Synchronizes the serial line, detects and validates start bits, times mid-bit samples and shifts bits into a 10-bit shift register.
- Drives the remapping sub-module and latches the right-justified result as received data with parity, framing and overrun status.
- Sits between the RX pin and the processor's read/status port.

Parameters:
- BAUD_W, 19, width of the bit-time count (covers 300 baud at 100 MHz, k = 333333).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx  in  1  raw serial input, asynchronous, idle high.
- baud_k  in  BAUD_W  clocks per bit; must be ≥ 4.
- eight  in  1  1 = 8 data bits, 0 = 7.
- pen  in  1  parity enable.
- ohel  in  1  parity sense: 0 = even, 1 = odd.
- clr_rdy  in  1  one-cycle pulse from processor data read; clears rxrdy and ovf.
- rx_data  out  8  received data; bit 7 forced 0 in 7-bit mode.
- rxrdy  out  1  data available.
- perr  out  1  parity error for the frame in rx_data.
- ferr  out  1  framing error (stop bit = 0) for the frame in rx_data.
- ovf  out  1  overrun: a frame completed while rxrdy was already 1.

Behaviour:
- Reset (async, reset_n = 0):
  - All outputs and counters 0; state IDLE; shift register 10'h000.
  - Both synchronizer flops reset to 1.
- Synchronizer: rx passes through 2 flops (rx_s); all decisions use rx_s only.
- Frame config: eight and pen are latched into cfg_eight/cfg_pen on the IDLE→START transition. Changes mid-frame have no effect on the current frame.
- Frame bit count: N = 8 + cfg_eight + cfg_pen, counting data bits, optional parity and the stop bit (8, 9 or 10).
- States:
  - IDLE: bit counter and bit-time counter cleared. rx_s = 0 → START.
  - START:
    - Bit-time counter runs to baud_k >> 1.
    - At terminal count: rx_s = 0 → DATA with counter cleared; rx_s = 1 → IDLE (false start, no status change).
  - DATA:
    - Counter runs to baud_k - 1, i.e. one sample every baud_k cycles at mid-bit.
    - At each sample, shift right with rx_s into bit 9: sr <= {rx_s, sr[9:1]}; bit counter +1.
    - After sample N → DONE.
  - DONE (exactly 1 cycle):
    - Latch rx_data, perr, ferr; set rxrdy.
    - ovf <= 1 if rxrdy was already 1 (new data overwrites old).
    - Clear shift register → IDLE.
- Remap: sr feeds remapping (d_in = sr, eight = cfg_eight, pen = cfg_pen), giving d_out right-justified with data in d_out[6:0].
- Field extraction from d_out:
  - Data: eight ? d_out[7:0] : {0, d_out[6:0]}.
  - Parity bit: d_out[8] if cfg_eight, else d_out[7].
  - Stop bit: d_out[7 + cfg_eight + cfg_pen].
- Parity check:
  - Expected parity = (^data) XOR ohel; ohel is sampled in DONE.
  - perr = cfg_pen & (parity bit ≠ expected). perr = 0 when cfg_pen = 0.
- ferr = ~stop bit.
- clr_rdy:
  - Clears rxrdy and ovf next cycle.
  - Same cycle as DONE: set wins for rxrdy. ovf is then computed against the pre-clear rxrdy, i.e. clear takes priority and ovf = 0.
- Latency: rxrdy rises 1 cycle after the final mid-bit stop-bit sample.
- No break detection. A line held low restarts the frame after returning through IDLE.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams (IDLE, START, DATA, DONE).
  - Frame-length constants (MIN_BITS = 8, SR_W = 10).
- Sub-module: instance of the existing remapping block. The synchronizer stays inline.

Test Plan:
- baud_k = 16, 8N1 (eight = 1, pen = 0), send 0xA5 → after the stop-bit sample, rxrdy = 1, rx_data = 0xA5, perr = 0, ferr = 0.
- baud_k = 16, 7E1 (eight = 0, pen = 1, ohel = 0), send 0x41 with parity 0 → rx_data = 0x41, perr = 0. Repeat with parity bit 1 → perr = 1.
- 8O1 (ohel = 1), send 0x00 with parity 1 and stop = 0 → rx_data = 0x00, perr = 0, ferr = 1.
- Start glitch: rx low for 4 clocks, then high (baud_k = 16) → returns to IDLE, rxrdy stays 0, no status change.
- Two 8N1 frames (0x11, 0x22) with no clr_rdy → rx_data = 0x22, ovf = 1. Pulse clr_rdy → rxrdy = 0, ovf = 0.
- Assert reset_n = 0 mid-DATA of a frame → all outputs 0 immediately. After release with rx high, a fresh 0x5A frame is received correctly.
